data_mem_responder: RTL and testbench

//  Multi-cycle data-memory responder answering the mRD/mWR requests the CPU control unit issues in its

---
 rtl/cpu_pkg.sv | 16 +
 rtl/dm_byte_ram.sv | 36 +++
 rtl/data_mem_responder.sv | 113 +++++++++++
 tb/tb_data_mem_responder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Encodings shared between the CPU control unit and the data-memory responder.
// Holds the responder state codes, load/store opcodes and the wait-counter width.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [5:0] OP_SW = 6'b110000;
  localparam logic [5:0] OP_LW = 6'b110001;

  localparam int CNT_W = 4;

endpackage

// File: rtl/dm_byte_ram.sv
// Byte-addressed RAM with a word-aligned 32-bit big-endian port.
// The write is synchronous and the read data is registered; only the read register is reset.
module dm_byte_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-3:0] word,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [7:0] mem [2**ADDR_W];

  // Most significant byte lives at the lowest address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[{word, 2'b00}] <= wdata[31:24];
      mem[{word, 2'b01}] <= wdata[23:16];
      mem[{word, 2'b10}] <= wdata[15:8];
      mem[{word, 2'b11}] <= wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= {mem[{word, 2'b00}], mem[{word, 2'b01}],
                mem[{word, 2'b10}], mem[{word, 2'b11}]};
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts a one-cycle req, waits WAIT_CYCLES,
// then completes the load/store with a single ready pulse (plus err when rejected).
module data_mem_responder
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        mRD,
  input  logic        mWR,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        ready,
  output logic        err
);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              rd_q, wr_q, bad_q;
  logic [ADDR_W-3:0] word_q;
  logic [31:0]       wdata_q;
  logic              sel_rd, sel_wr, sel_bad;
  logic [ADDR_W-3:0] sel_word;
  logic [31:0]       sel_wdata;
  logic              go_done, ram_we, ram_re;

  function automatic logic req_rejected(input logic rd, input logic wr, input logic [31:0] a);
    return (rd == wr) || (a[1:0] != 2'b00) || ((a >> ADDR_W) != 32'd0);
  endfunction

  assign accept = (state == ST_IDLE) && req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (accept)
        cnt <= CNT_W'(WAIT_CYCLES);
      else if (state == ST_WAIT)
        cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (req) state_nx = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
      ST_WAIT: if (cnt <= CNT_W'(1)) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Request fields are captured once; later changes on the inputs are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_q    <= mRD;
      wr_q    <= mWR;
      bad_q   <= req_rejected(mRD, mWR, addr);
      word_q  <= addr[ADDR_W-1:2];
      wdata_q <= wdata;
    end
  end

  // With zero wait states DONE is entered straight from IDLE, so the live inputs
  // must drive the access instead of the not-yet-captured copies.
  always_comb begin
    if (state == ST_IDLE) begin
      sel_rd    = mRD;
      sel_wr    = mWR;
      sel_bad   = req_rejected(mRD, mWR, addr);
      sel_word  = addr[ADDR_W-1:2];
      sel_wdata = wdata;
    end else begin
      sel_rd    = rd_q;
      sel_wr    = wr_q;
      sel_bad   = bad_q;
      sel_word  = word_q;
      sel_wdata = wdata_q;
    end
  end

  // The access is clocked on the edge entering DONE so read data appears with ready
  // and a reset during WAIT leaves the RAM untouched.
  assign go_done = (state_nx == ST_DONE) && (state != ST_DONE);
  assign ram_we  = go_done && sel_wr && !sel_bad;
  assign ram_re  = go_done && sel_rd && !sel_bad;

  dm_byte_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .re   (ram_re),
    .word (sel_word),
    .wdata(sel_wdata),
    .rdata(rdata)
  );

  assign busy  = (state != ST_IDLE);
  assign ready = (state == ST_DONE);
  assign err   = ready && bad_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a 2-wait-state instance and a 0-wait-state instance
// driven from one linear sequence, with hand-computed expectations.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0, rd0, wr0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        busy0, ready0, err0;
  logic        req1, rd1, wr1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        busy1, ready1, err1;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .req(req0), .mRD(rd0), .mWR(wr0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .busy(busy0), .ready(ready0), .err(err0)
  );

  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .req(req1), .mRD(rd1), .mWR(wr1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .busy(busy1), .ready(ready1), .err(err1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Full transaction on the 2-wait instance: req at N, ready expected at N+3 only.
  task automatic txn0(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic exp_err, input bit chk_rd,
                      input logic [31:0] exp_rd);
    req0 = 1'b1; rd0 = rd; wr0 = wr; addr0 = a; wdata0 = d;
    tick;
    req0 = 1'b0; rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
    check({tag, " busy N+1"},  32'(busy0),  32'd1);
    check({tag, " ready N+1"}, 32'(ready0), 32'd0);
    tick;
    check({tag, " ready N+2"}, 32'(ready0), 32'd0);
    tick;
    check({tag, " ready N+3"}, 32'(ready0), 32'd1);
    check({tag, " err N+3"},   32'(err0),   32'(exp_err));
    if (chk_rd) check({tag, " rdata"}, rdata0, exp_rd);
    tick;
    check({tag, " ready N+4"}, 32'(ready0), 32'd0);
    check({tag, " busy N+4"},  32'(busy0),  32'd0);
  endtask

  // Transaction on the 0-wait instance: ready expected at N+1, next req may go at N+2.
  task automatic txn1(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic exp_err, input bit chk_rd,
                      input logic [31:0] exp_rd);
    req1 = 1'b1; rd1 = rd; wr1 = wr; addr1 = a; wdata1 = d;
    tick;
    req1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    check({tag, " ready N+1"}, 32'(ready1), 32'd1);
    check({tag, " err N+1"},   32'(err1),   32'(exp_err));
    if (chk_rd) check({tag, " rdata"}, rdata1, exp_rd);
    tick;
    check({tag, " ready N+2"}, 32'(ready1), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nready, nbusy;
    rst = 1'b0;
    req0 = 0; rd0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; rd1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
    tick;
    tick;
    check("reset rdata", rdata0, 32'h0);
    check("reset busy",  32'(busy0),  32'd0);
    check("reset ready", 32'(ready0), 32'd0);
    check("reset err",   32'(err0),   32'd0);
    rst = 1'b1;
    tick;

    // Store then load at 0x10.
    txn0("sw10", 1'b0, 1'b1, 32'h10, 32'h12345678, 1'b0, 1'b0, 32'h0);
    check("mem 0x10", {24'h0, u0.u_ram.mem[16]}, 32'h12);
    check("mem 0x13", {24'h0, u0.u_ram.mem[19]}, 32'h78);
    check("rdata after sw", rdata0, 32'h0);
    txn0("lw10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h12345678);

    // Rejected requests: rdata and RAM must stay put.
    txn0("lw12 misaligned", 1'b1, 1'b0, 32'h12, 32'h0, 1'b1, 1'b1, 32'h12345678);
    check("mem 0x12 kept", {24'h0, u0.u_ram.mem[18]}, 32'h56);
    txn0("rd+wr", 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 1'b1, 32'h12345678);
    txn0("sw 0x100", 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 1'b1, 32'h12345678);
    txn0("no op", 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    check("mem 0x10 kept", {24'h0, u0.u_ram.mem[16]}, 32'h12);
    check("mem 0x11 kept", {24'h0, u0.u_ram.mem[17]}, 32'h34);
    txn0("lw10 again", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h12345678);

    // A second req during WAIT must be ignored entirely.
    req0 = 1'b1; rd0 = 1'b0; wr0 = 1'b1; addr0 = 32'h20; wdata0 = 32'hA5A5A5A5;
    tick;
    rd0 = 1'b1; wr0 = 1'b0; addr0 = 32'h20; wdata0 = 32'h0;
    nready = 0; nbusy = 0;
    for (int i = 0; i < 5; i++) begin
      nready += int'(ready0);
      nbusy  += int'(busy0);
      tick;
      req0 = 1'b0; rd0 = 1'b0;
    end
    check("ignored req ready pulses", 32'(nready), 32'd1);
    check("ignored req busy cycles",  32'(nbusy),  32'd3);
    check("ignored read not done", rdata0, 32'h12345678);
    txn0("lw20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'hA5A5A5A5);

    // Reset in the middle of WAIT aborts the store.
    req0 = 1'b1; rd0 = 1'b0; wr0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hCAFEF00D;
    tick;
    req0 = 1'b0; wr0 = 1'b0;
    check("pre-reset busy", 32'(busy0), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async rst busy",  32'(busy0),  32'd0);
    check("async rst ready", 32'(ready0), 32'd0);
    check("async rst err",   32'(err0),   32'd0);
    check("async rst rdata", rdata0, 32'h0);
    tick;
    rst = 1'b1;
    tick;
    txn0("lw10 after rst", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h12345678);

    // Zero-wait instance, requests every other cycle.
    txn1("z sw44", 1'b0, 1'b1, 32'h44, 32'h55667788, 1'b0, 1'b0, 32'h0);
    txn1("z sw40", 1'b0, 1'b1, 32'h40, 32'h11223344, 1'b0, 1'b0, 32'h0);
    txn1("z lw44", 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b1, 32'h55667788);
    txn1("z lw40", 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 32'h11223344);
    txn1("z misaligned", 1'b1, 1'b0, 32'h41, 32'h0, 1'b1, 1'b1, 32'h11223344);
    check("z busy idle", 32'(busy1), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
